// File: rtl/upower_fetch_pkg.sv
// Shared types and constants for the uPower fetch unit.
// Build option: FETCH_TRACE_EN prints every instruction handed to decode.
package upower_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam int QDEPTH       = 2;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {pc, inst}; flush beats push.
// Entry 0 is always the head, entry 1 the tail when full.
module fetch_queue
  import upower_fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_inst,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [PC_W-1:0]   head_pc,
  output logic [DATA_W-1:0] head_inst
);

  logic [PC_W-1:0]   tail_pc;
  logic [DATA_W-1:0] tail_inst;
  logic              pop_ok;
  logic              push_ok;
  logic              do_both;
  logic              do_pop;
  logic              do_push;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push &&
                   ((count < 2'(QDEPTH)) || pop_ok);

  assign do_both = !flush && push_ok && pop_ok;
  assign do_pop  = !flush && pop_ok && !push_ok;
  assign do_push = !flush && push_ok && !pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_pc   <= '0;
      head_inst <= '0;
      tail_pc   <= '0;
      tail_inst <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          count <= 2'd0;
        end
        do_both: begin
          if (count == 2'd2) begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            tail_pc   <= push_pc;
            tail_inst <= push_inst;
          end else begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
          end
        end
        do_pop: begin
          head_pc   <= tail_pc;
          head_inst <= tail_inst;
          count     <= count - 2'd1;
        end
        do_push: begin
          if (count == 2'd0) begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
          end else begin
            tail_pc   <= push_pc;
            tail_inst <= push_inst;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// uPower fetch controller: PC, imem sequencing, prefetch queue, redirects.
// Build option: FETCH_TRACE_EN displays each completed transfer.
module fetch_sequencer
  import upower_fetch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int IMEM_DEPTH = 4,
  parameter int RESET_PC   = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic              busy,
  output logic              halted
);

  localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] RST   = PC_W'(RESET_PC);

  state_t          state;
  logic [PC_W-1:0] fpc;
  logic [PC_W-1:0] rd_pc;
  logic            inflight;
  logic [1:0]      count;
  logic [2:0]      occ;
  logic            pop;
  logic            flush;
  logic            in_range;
  logic            redir_ok;
  logic            done;

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign flush      = redirect_valid && (state != IDLE);
  assign in_range   = (fpc < DEPTH);
  assign redir_ok   = redirect_valid && (redirect_pc < DEPTH);

  // occupancy counts the word already on its way back
  assign occ = {1'b0, count} + {2'b0, inflight}
             - {2'b0, pop};

  assign imem_req  = (state == RUN) && !redirect_valid &&
                     in_range && (occ < 3'(QDEPTH));
  assign imem_addr = fpc;

  assign done = !in_range && !inflight &&
                ((count == 2'd0) ||
                 ((count == 2'd1) && pop));

  fetch_queue #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_pc   (rd_pc),
    .push_inst (imem_rdata),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_pc   (inst_pc),
    .head_inst (inst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fpc      <= RST;
      rd_pc    <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) rd_pc <= fpc;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            fpc   <= RST;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            fpc <= redirect_pc;
            if (!redir_ok) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          end else begin
            if (imem_req) fpc <= fpc + 1'b1;
            if (done) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redir_ok) begin
            state  <= RUN;
            fpc    <= redirect_pc;
            busy   <= 1'b1;
            halted <= 1'b0;
          end else if (start) begin
            state  <= RUN;
            fpc    <= RST;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && pop)
      $display("fetch pc=%0d inst=%b", inst_pc, inst);
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table plus scoreboarded sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        busy;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } tr_t;

  tr_t exp_q[$];

  typedef struct {
    logic        start;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_W     (32),
    .PC_W       (32),
    .IMEM_DEPTH (4),
    .RESET_PC   (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .busy           (busy),
    .halted         (halted)
  );

  function automatic logic [31:0] word_at(int i);
    case (i)
      0: return 32'h3820_0001;
      1: return 32'h3840_0002;
      2: return 32'h7C22_1A14;
      3: return 32'h4800_0000;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_req && imem_addr < 32'd4)
      imem_rdata <= word_at(int'(imem_addr));
    else
      imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_unexpected: got pc %h want none",
                 inst_pc);
      end else begin
        tr_t t;
        t = exp_q.pop_front();
        chk("xfer_pc", inst_pc, t.pc);
        chk("xfer_inst", inst, t.word);
      end
    end
  end

  task automatic push_exp(int lo, int hi);
    for (int p = lo; p <= hi; p++)
      exp_q.push_back({32'(p), word_at(p)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halted(string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk(name, {31'b0, halted}, 32'd1);
    next_cycle();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_pc"}, inst_pc, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    int nreq;
    logic [31:0] a0, a1;
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 1, 0, 0, 1, 0};
    tbl[3] = '{0, 1, 1, 2, 1, 0, 1, 0};
    tbl[4] = '{0, 1, 1, 3, 1, 1, 1, 0};
    tbl[5] = '{0, 1, 0, 0, 1, 2, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 1, 3, 1, 0};
    tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    next_cycle();

    // straight-line run
    push_exp(0, 3);
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start;
      inst_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i),
          {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req)
        chk($sformatf("tbl%0d_addr", i),
            imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i),
          {31'b0, inst_valid}, {31'b0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), inst,
            word_at(int'(tbl[i].pc)));
      end
      chk($sformatf("tbl%0d_busy", i),
          {31'b0, busy}, {31'b0, tbl[i].busy});
      chk($sformatf("tbl%0d_halted", i),
          {31'b0, halted}, {31'b0, tbl[i].halted});
      next_cycle();
    end
    start = 1'b0;

    // back-pressure from the start
    inst_ready = 1'b0;
    start = 1'b1;
    nreq = 0;
    a0 = 32'hFFFF_FFFF;
    a1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) begin
        if (nreq == 0) a0 = imem_addr;
        if (nreq == 1) a1 = imem_addr;
        nreq++;
      end
      if (i >= 3) begin
        chk("bp_valid", {31'b0, inst_valid}, 32'd1);
        chk("bp_pc", inst_pc, 32'd0);
        chk("bp_inst", inst, word_at(0));
      end
      next_cycle();
      start = 1'b0;
    end
    chk("bp_nreq", 32'(nreq), 32'd2);
    chk("bp_addr0", a0, 32'd0);
    chk("bp_addr1", a1, 32'd1);
    push_exp(0, 3);
    inst_ready = 1'b1;
    wait_halted("bp_halt");

    // redirect to 0 while pc 2 is accepted
    push_exp(0, 2);
    push_exp(0, 3);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    @(negedge clk);
    chk("rd_k_head", inst_pc, 32'd2);
    chk("rd_k_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_k1_valid", {31'b0, inst_valid}, 32'd0);
    chk("rd_k1_req", {31'b0, imem_req}, 32'd1);
    chk("rd_k1_addr", imem_addr, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_k2_valid", {31'b0, inst_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_k3_valid", {31'b0, inst_valid}, 32'd1);
    chk("rd_k3_pc", inst_pc, 32'd0);
    next_cycle();
    wait_halted("rd_halt");

    // from HALT, redirect into range
    push_exp(1, 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'd1;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("hr_busy", {31'b0, busy}, 32'd1);
    chk("hr_addr", imem_addr, 32'd1);
    next_cycle();
    wait_halted("hr_halt");

    // out-of-range redirect while running
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    @(negedge clk);
    chk("oor_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("oor_halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("oor_novalid", {31'b0, inst_valid}, 32'd0);
    end
    next_cycle();

    // async reset with two words queued
    inst_ready = 1'b0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    chk("mr_valid", {31'b0, inst_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
    push_exp(0, 3);
    inst_ready = 1'b1;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("mr_restart_addr", imem_addr, 32'd0);
    next_cycle();
    wait_halted("mr_halt");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the uPower core: owns the program counter, sequences word-indexed reads of the synchronous instruction memory, buffers returned words in a 2-entry prefetch queue and hands them to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage and accepts branch/jump redirects from execute.

## Interface
- `DATA_W`, 32, instruction width
- `PC_W`, 32, program-counter width; the PC is a word index (instruction n at index n, increment by 1)
- `IMEM_DEPTH`, 4, number of instruction words; valid indices 0..IMEM_DEPTH-1
- `RESET_PC`, 0, first fetch index after `start`

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins fetching from `RESET_PC`
- `imem_req`  out  1  read strobe to instruction memory
- `imem_addr`  out  PC_W  word index of the read
- `imem_rdata`  in  DATA_W  read data, valid the cycle after `imem_req`
- `redirect_valid`  in  1  taken branch/jump from execute
- `redirect_pc`  in  PC_W  new fetch index
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction
- `inst`  out  DATA_W  instruction word at queue head
- `inst_pc`  out  PC_W  index of that word
- `inst_ready`  in  1  decode accepts; transfer when `inst_valid && inst_ready`
- `busy`  out  1  state is RUN
- `halted`  out  1  state is HALT

## Operation
- FSM: IDLE → RUN on `start`; RUN → HALT when fetch PC ≥ IMEM_DEPTH, nothing in flight and queue empty; HALT → RUN on `redirect_valid` with `redirect_pc` < IMEM_DEPTH, or on `start` (restart at `RESET_PC`). `start` in RUN is ignored.
- Issue rule (RUN only): `imem_req` = 1 when fetch PC < IMEM_DEPTH and (queue count + in-flight − pop this cycle) < 2. On issue the fetch PC increments by 1.
- Return: word arriving the cycle after a request is pushed with its index, unless killed.
- Redirect: flushes the queue, marks the in-flight read killed (its data discarded), loads fetch PC = `redirect_pc`; no `imem_req` in the redirect cycle. A transfer coinciding with the redirect completes normally. Redirect with `redirect_pc` ≥ IMEM_DEPTH → HALT next cycle after flush.
- `inst`/`inst_pc` stable while `inst_valid && !inst_ready`.
- Fetch index wraps nowhere: PC_W arithmetic, PC ≥ IMEM_DEPTH simply stops issue.
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `busy`=0, `halted`=0; queue empty, no read in flight, state IDLE. Reset mid-fetch abandons everything immediately (async).

## Timing
- `start` high in cycle 0 → `imem_req` with addr RESET_PC in cycle 1 → data pushed at end of cycle 2 → `inst_valid` cycle 3 (start-to-first-instruction 3 cycles).
- Steady state with `inst_ready`=1: one instruction per cycle, consecutive `inst_pc`.
- Redirect in cycle k → first `imem_req` to target in k+1 → `inst_valid` for target in k+3; `inst_valid` low in k+1..k+2.
- Back-pressure: with `inst_ready`=0 at most 2 words queued, `imem_req` stops, no data lost.

## Configuration
- `FETCH_TRACE_EN`: defined → on every completed transfer, simulation `$display` of `inst` (32-bit binary) and `inst_pc`; undefined → no display statements compiled, behaviour otherwise identical.

## Structure
- Package `upower_fetch_pkg`: state enum (IDLE, RUN, HALT), queue depth constant 2, default `RESET_PC`.
- Sub-module `fetch_queue`: 2-entry FIFO of {pc, inst} with push/pop, count, flush; flush takes priority over push in the same cycle.

## Test plan
- IMEM_DEPTH=4, `start` pulse, `inst_ready`=1 → `inst_pc` 0,1,2,3 in cycles 3..6, `halted`=1 in cycle 7, no further `imem_req`.
- `inst_ready`=0 from cycle 0, `start` → exactly 2 requests (addr 0,1), queue holds 2, `inst`/`inst_pc` frozen at index 0; release → 0,1,2,3 delivered in order.
- Redirect to 0 in cycle when `inst_pc`=2 accepted → index 2 delivered once, in-flight index 3 discarded, next delivered `inst_pc`=0 three cycles later.
- From HALT, redirect to 1 → RUN, delivers 1,2,3, halts again; redirect to 7 from RUN → HALT with no `inst_valid` after.
- Assert `rst_n`=0 mid-stream with 2 queued → all outputs to reset values immediately; `start` afterward restarts at index 0.
